// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC operand feeder and its operand store.
package mac_pkg;

  localparam int unsigned MAC_WIDTH     = 10;
  localparam int unsigned MAC_ACC_WIDTH = 20;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_t;

  typedef logic signed [MAC_WIDTH-1:0]     operand_t;
  typedef logic signed [MAC_ACC_WIDTH-1:0] acc_t;

endpackage

// File: rtl/mac_operand_ram.sv
// Operand store: DEPTH entries of packed {A, B}; synchronous write, combinational read.
module mac_operand_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 20,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  // Contents survive reset by design, so no reset branch here.
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mac_operand_feeder.sv
// Streams stored A/B operand pairs into a 2-cycle MAC and returns the dot product.
// Optional drain timeout and timeout port enabled by defining MAC_FEEDER_TIMEOUT_EN.
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH     = MAC_WIDTH,
  parameter int unsigned ACC_WIDTH = MAC_ACC_WIDTH,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AW        = $clog2(DEPTH),
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_a,
  input  logic [WIDTH-1:0]     wr_b,
  input  logic                 start,
  input  logic [AW:0]          length,
  output logic                 mac_clr,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic                 valid_out,
  input  logic [ACC_WIDTH-1:0] mac_f,
  input  logic                 mac_valid,
  output logic                 busy,
  output logic                 done,
`ifdef MAC_FEEDER_TIMEOUT_EN
  output logic                 timeout,
`endif
  output logic [ACC_WIDTH-1:0] result
);

  typedef logic [AW:0] cnt_t;
  localparam cnt_t DepthCnt = cnt_t'(DEPTH);

  feeder_state_t state_q, state_d;
  cnt_t len_q, len_d;
  cnt_t idx_q, idx_d;
  cnt_t rcnt_q, rcnt_d;
  cnt_t len_sat, rcnt_inc;

  logic                 mac_clr_q, mac_clr_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;

  logic [AW-1:0]        rd_addr;
  logic [2*WIDTH-1:0]   rd_data;
  logic [WIDTH-1:0]     rd_a, rd_b;

  mac_operand_ram #(
    .DEPTH (DEPTH),
    .DW    (2 * WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en && (state_q == IDLE)),
    .waddr (wr_addr),
    .wdata ({wr_a, wr_b}),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Entry 0 is presented during CLEAR so the first pair issues on the next cycle.
  assign rd_addr  = (state_q == STREAM) ? idx_q[AW-1:0] : '0;
  assign rd_a     = rd_data[2*WIDTH-1:WIDTH];
  assign rd_b     = rd_data[WIDTH-1:0];
  assign len_sat  = (length > DepthCnt) ? DepthCnt : length;
  assign rcnt_inc = rcnt_q + 1'b1;

`ifdef MAC_FEEDER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  typedef logic [TW-1:0] tcnt_t;
  localparam tcnt_t TimeoutLast = tcnt_t'(TIMEOUT - 1);

  tcnt_t drain_q, drain_d;
  logic  timeout_q, timeout_d;

  assign timeout = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    rcnt_d    = rcnt_q;
    mac_clr_d = 1'b0;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    a_d       = '0;
    b_d       = '0;
    result_d  = result_q;
`ifdef MAC_FEEDER_TIMEOUT_EN
    drain_d   = drain_q;
    timeout_d = timeout_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d = len_sat;
`ifdef MAC_FEEDER_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          if (len_sat == '0) begin
            state_d  = DONE;
            result_d = '0;
            done_d   = 1'b1;
          end else begin
            state_d   = CLEAR;
            mac_clr_d = 1'b1;
          end
        end
      end

      CLEAR: begin
        a_d     = rd_a;
        b_d     = rd_b;
        valid_d = 1'b1;
        idx_d   = cnt_t'(1);
        rcnt_d  = '0;
        state_d = STREAM;
`ifdef MAC_FEEDER_TIMEOUT_EN
        drain_d = '0;
`endif
      end

      STREAM: begin
        if (mac_valid) begin
          rcnt_d = rcnt_inc;
        end
        if (idx_q == len_q) begin
          state_d = DRAIN;
        end else begin
          a_d     = rd_a;
          b_d     = rd_b;
          valid_d = 1'b1;
          idx_d   = idx_q + 1'b1;
        end
      end

      DRAIN: begin
        if (mac_valid && (rcnt_inc == len_q)) begin
          rcnt_d   = rcnt_inc;
          result_d = mac_f;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          if (mac_valid) begin
            rcnt_d = rcnt_inc;
          end
`ifdef MAC_FEEDER_TIMEOUT_EN
          if (drain_q == TimeoutLast) begin
            result_d  = mac_f;
            done_d    = 1'b1;
            timeout_d = 1'b1;
            state_d   = DONE;
          end else begin
            drain_d = drain_q + 1'b1;
          end
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      rcnt_q    <= '0;
      mac_clr_q <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      rcnt_q    <= rcnt_d;
      mac_clr_q <= mac_clr_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
    end
  end

`ifdef MAC_FEEDER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      drain_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      drain_q   <= drain_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  assign mac_clr   = mac_clr_q;
  assign valid_out = valid_q;
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign done      = done_q;
  assign result    = result_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder driving a behavioural 2-cycle signed MAC.
module tb_mac_operand_feeder;
  import mac_pkg::*;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [9:0]  wr_a, wr_b;
  logic        start;
  logic [3:0]  length;
  logic        mac_clr;
  logic [9:0]  a_out, b_out;
  logic        valid_out;
  logic [19:0] mac_f;
  logic        mac_valid;
  logic        busy, done;
  logic [19:0] result;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  mac_operand_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_a      (wr_a),
    .wr_b      (wr_b),
    .start     (start),
    .length    (length),
    .mac_clr   (mac_clr),
    .a_out     (a_out),
    .b_out     (b_out),
    .valid_out (valid_out),
    .mac_f     (mac_f),
    .mac_valid (mac_valid),
    .busy      (busy),
    .done      (done),
`ifdef MAC_FEEDER_TIMEOUT_EN
    .timeout   (timeout),
`endif
    .result    (result)
  );

`ifndef MAC_FEEDER_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference MAC: product stage, then accumulate stage; strobes can be gated.
  logic signed [19:0] prod_q, acc_q;
  logic               pv_q, mv_q;
  int                 passed = 0;
  int                 gate_at = 32'h7fffffff;

  always @(posedge clk) begin
    if (reset || mac_clr) begin
      prod_q <= '0;
      acc_q  <= '0;
      pv_q   <= 1'b0;
      mv_q   <= 1'b0;
    end else begin
      prod_q <= 20'($signed(a_out)) * 20'($signed(b_out));
      pv_q   <= valid_out;
      mv_q   <= pv_q;
      if (pv_q) acc_q <= acc_q + prod_q;
    end
    if (mac_valid) passed <= passed + 1;
  end

  assign mac_f     = acc_q;
  assign mac_valid = mv_q && (passed < gate_at);

  task automatic write_entry(input logic [2:0] addr, input operand_t a, input operand_t b);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = addr; wr_a = a; wr_b = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Starts a run and observes it until done; lat is cycles from start edge, -1 if none.
  task automatic run(input logic [3:0] len, input logic do_wr, input operand_t wa,
                     input operand_t wb, output int clr_n, output int vld_n,
                     output int bursts, output int lat, output logic [19:0] res,
                     output logic to);
    logic prev;
    clr_n = 0; vld_n = 0; bursts = 0; lat = -1; res = '0; to = 1'b0; prev = 1'b0;
    @(negedge clk);
    start = 1'b1; length = len;
    if (do_wr) begin
      wr_en = 1'b1; wr_addr = 3'd0; wr_a = wa; wr_b = wb;
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (mac_clr) clr_n++;
      if (valid_out) begin
        vld_n++;
        if (!prev) bursts++;
      end
      prev = valid_out;
      if (done) begin
        lat = k; res = result; to = timeout;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: busy=%b done=%b want 0 0", busy, done);
    end
    total++; if (mac_clr !== 1'b0 || valid_out !== 1'b0) begin
      bad++; $display("FAIL reset_mac: mac_clr=%b valid_out=%b want 0 0", mac_clr, valid_out);
    end
    total++; if (a_out !== '0 || b_out !== '0 || result !== '0) begin
      bad++; $display("FAIL reset_data: a=%h b=%h result=%h want 0", a_out, b_out, result);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int c, v, bu, lat; logic [19:0] r; logic to;
    write_entry(3'd0, 10'sd1, 10'sd4);
    write_entry(3'd1, 10'sd2, 10'sd5);
    write_entry(3'd2, 10'sd3, 10'sd6);
    run(4'd3, 1'b0, '0, '0, c, v, bu, lat, r, to);
    total++; if (c !== 1) begin bad++; $display("FAIL basic_clr: got %0d want 1", c); end
    total++; if (v !== 3 || bu !== 1) begin
      bad++; $display("FAIL basic_pairs: got %0d in %0d bursts want 3 in 1", v, bu);
    end
    total++; if (lat !== 7) begin bad++; $display("FAIL basic_lat: got %0d want 7", lat); end
    total++; if (r !== 20'd32) begin bad++; $display("FAIL basic_res: got %0d want 32", r); end
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0 || result !== 20'd32) begin
      bad++; $display("FAIL basic_after: done=%b busy=%b result=%0d want 0 0 32", done, busy,
                      result);
    end
  endtask

  task automatic test_extremes;
    int c, v, bu, lat; logic [19:0] r; logic to;
    write_entry(3'd0, -10'sd512, -10'sd512);
    run(4'd1, 1'b0, '0, '0, c, v, bu, lat, r, to);
    total++; if (r !== 20'd262144 || lat !== 5) begin
      bad++; $display("FAIL neg_neg: got %0d lat %0d want 262144 lat 5", $signed(r), lat);
    end
    write_entry(3'd0, 10'sd511, -10'sd512);
    run(4'd1, 1'b0, '0, '0, c, v, bu, lat, r, to);
    total++; if (r !== acc_t'(-261632)) begin
      bad++; $display("FAIL pos_neg: got %0d want -261632", $signed(r));
    end
    // Write in the start cycle must be seen by the run.
    run(4'd1, 1'b1, 10'sd7, -10'sd3, c, v, bu, lat, r, to);
    total++; if (r !== acc_t'(-21)) begin
      bad++; $display("FAIL wr_with_start: got %0d want -21", $signed(r));
    end
  endtask

  task automatic test_zero_len;
    int c, v, bu, lat; logic [19:0] r; logic to;
    run(4'd0, 1'b0, '0, '0, c, v, bu, lat, r, to);
    total++; if (c !== 0 || v !== 0) begin
      bad++; $display("FAIL zero_traffic: clr=%0d pairs=%0d want 0 0", c, v);
    end
    total++; if (lat !== 1 || r !== '0) begin
      bad++; $display("FAIL zero_done: lat=%0d res=%0d want 1 0", lat, r);
    end
  endtask

  task automatic test_saturate;
    int c, v, bu, lat; logic [19:0] r; logic to;
    for (int i = 0; i < 8; i++) write_entry(3'(i), 10'sd1, 10'sd2);
    run(4'd12, 1'b0, '0, '0, c, v, bu, lat, r, to);
    total++; if (v !== 8 || bu !== 1) begin
      bad++; $display("FAIL sat_pairs: got %0d in %0d bursts want 8 in 1", v, bu);
    end
    total++; if (r !== 20'd16 || lat !== 12) begin
      bad++; $display("FAIL sat_res: got %0d lat %0d want 16 lat 12", r, lat);
    end
  endtask

  task automatic test_busy_ignore;
    int v, lat, extra; logic [19:0] r; int c, bu; logic to;
    v = 0; lat = -1; r = '0; extra = 0;
    @(negedge clk);
    start = 1'b1; length = 4'd8;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (valid_out) v++;
      if (done) begin lat = k; r = result; break; end
      if (k == 4) begin
        start = 1'b1; length = 4'd1;
        wr_en = 1'b1; wr_addr = 3'd0; wr_a = 10'sd100; wr_b = 10'sd100;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; wr_en = 1'b0;
    total++; if (v !== 8 || r !== 20'd16 || lat !== 12) begin
      bad++; $display("FAIL busy_run: pairs=%0d res=%0d lat=%0d want 8 16 12", v, r, lat);
    end
    repeat (5) begin
      @(negedge clk);
      if (busy) extra++;
    end
    total++; if (extra !== 0) begin
      bad++; $display("FAIL busy_start: busy cycles=%0d want 0", extra);
    end
    run(4'd1, 1'b0, '0, '0, c, v, bu, lat, r, to);
    total++; if (r !== 20'd2) begin
      bad++; $display("FAIL busy_store: got %0d want 2", r);
    end
  endtask

  task automatic test_reset_in_drain;
    int dones; logic seen, in_drain;
    seen = 1'b0; in_drain = 1'b0; dones = 0;
    gate_at = passed;
    @(negedge clk);
    start = 1'b1; length = 4'd2;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (valid_out) seen = 1'b1;
      if (seen && !valid_out && busy) begin in_drain = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (in_drain !== 1'b1) begin
      bad++; $display("FAIL drain_reach: got %b want 1", in_drain);
    end
    reset = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || valid_out !== 1'b0 || mac_clr !== 1'b0
                 || result !== '0 || a_out !== '0) begin
      bad++; $display("FAIL drain_reset: busy=%b done=%b valid=%b clr=%b result=%0d a=%0d",
                      busy, done, valid_out, mac_clr, result, a_out);
    end
    reset = 1'b0;
    gate_at = 32'h7fffffff;
    repeat (10) begin
      @(negedge clk);
      if (done) dones++;
    end
    total++; if (dones !== 0) begin
      bad++; $display("FAIL drain_nodone: got %0d done pulses want 0", dones);
    end
  endtask

`ifdef MAC_FEEDER_TIMEOUT_EN
  task automatic test_timeout;
    int c, v, bu, lat; logic [19:0] r; logic to;
    gate_at = passed + 1;
    run(4'd3, 1'b0, '0, '0, c, v, bu, lat, r, to);
    total++; if (to !== 1'b1 || lat !== 20) begin
      bad++; $display("FAIL timeout_hit: timeout=%b lat=%0d want 1 20", to, lat);
    end
    total++; if (r !== 20'd6) begin
      bad++; $display("FAIL timeout_res: got %0d want 6", r);
    end
    gate_at = 32'h7fffffff;
    run(4'd1, 1'b0, '0, '0, c, v, bu, lat, r, to);
    total++; if (to !== 1'b0 || r !== 20'd2) begin
      bad++; $display("FAIL timeout_clear: timeout=%b res=%0d want 0 2", to, r);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0;
    start = 1'b0; length = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_zero_len();
    test_saturate();
    test_busy_ignore();
    test_reset_in_drain();
`ifdef MAC_FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_operand_feeder.md
Name: mac_operand_feeder

Overview:
- Upstream driver for the signed 10x10 multiply-accumulate unit.
- Holds two operand vectors A and B in a small local store, loaded through a write port.
- On start, clears the MAC, streams length operand pairs to it with a valid strobe, then counts the MAC's result strobes.
- Returns the final dot product with a one-cycle done pulse.

Parameters:
- WIDTH, 10, operand width, signed.
- ACC_WIDTH, 20, accumulator/result width, signed.
- DEPTH, 8, number of entries per operand vector (power of 2).
- AW, $clog2(DEPTH), address width (derived).
- TIMEOUT, 15, drain timeout in cycles (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe for the operand store.
- wr_addr  in  AW  entry index to write.
- wr_a  in  WIDTH  signed A operand to store.
- wr_b  in  WIDTH  signed B operand to store.
- start  in  1  begin a run (single-cycle pulse or level; sampled in IDLE only).
- length  in  AW+1  number of pairs to issue; sampled with start.
- mac_clr  out  1  one-cycle clear to the MAC; ORed with reset at the top level.
- a_out  out  WIDTH  A operand to the MAC.
- b_out  out  WIDTH  B operand to the MAC.
- valid_out  out  1  operand pair valid (drives the MAC valid_in).
- mac_f  in  ACC_WIDTH  MAC accumulator output.
- mac_valid  in  1  MAC result strobe.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- result  out  ACC_WIDTH  signed dot product; held until the next done.

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - Outputs: mac_clr=0, a_out=0, b_out=0, valid_out=0, busy=0, done=0, result=0.
  - State returns to IDLE; counters cleared.
  - Operand store contents are not cleared.
  - Reset mid-run aborts the run immediately; no done pulse.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE:
  - wr_en writes wr_a/wr_b to entry wr_addr on the clock edge.
  - On start: latch len = min(length, DEPTH).
    - If len==0, go to DONE with result<=0 and no MAC traffic.
    - Otherwise go to CLEAR.
  - wr_en and start in the same cycle: the write commits, and the run uses the new data.
- CLEAR: mac_clr=1 for exactly one cycle; issue index and result count reset to 0; go to STREAM.
- STREAM:
  - Each cycle: a_out/b_out = store[idx], valid_out=1, idx++.
  - Pairs issue back-to-back; there are no gaps.
  - After len pairs, go to DRAIN; valid_out=0 from that cycle.
- Result counting: mac_valid increments rcnt in STREAM and DRAIN; it is ignored in IDLE, CLEAR and DONE.
- DRAIN: when rcnt reaches len (on that mac_valid), result<=mac_f and go to DONE.
- DONE: done=1 for one cycle, busy=1; go to IDLE.
- start, and wr_en, are ignored while busy.
- Registered-output timing with the 2-cycle MAC, start sampled at edge T:
  - mac_clr is high in cycle T+1.
  - Pairs are issued in cycles T+2 .. T+1+len.
  - done is high in cycle T+4+len.
  - The bench must check done by counting strobes, not by this fixed latency alone.
- Arithmetic: no saturation; result equals mac_f bit-for-bit (two's-complement wrap at ACC_WIDTH).

Optional Feature:
- Macro: MAC_FEEDER_TIMEOUT_EN.
- When defined:
  - A DRAIN-cycle counter runs.
  - If TIMEOUT cycles pass in DRAIN without reaching len strobes: go to DONE, set result<=mac_f, and assert an extra output port timeout (1 bit) together with done.
  - timeout clears at the next start and on reset.
- When undefined: no timeout port, no counter, and DRAIN waits indefinitely.

Decomposition:
- Package mac_pkg:
  - WIDTH and ACC_WIDTH defaults.
  - State enum feeder_state_t {IDLE, CLEAR, STREAM, DRAIN, DONE}.
  - Signed operand and accumulator typedefs.
- Sub-module mac_operand_ram:
  - DEPTH x (2*WIDTH) storage.
  - Synchronous write, combinational read.
  - Instantiated once; the A and B fields are packed per entry.

Test Plan:
- Load A={1,2,3}, B={4,5,6}; start with length=3 -> exactly one mac_clr, 3 valid_out cycles back-to-back, done pulse, result=32.
- Load A[0]=-512, B[0]=-512; length=1 -> result=262144.
- Then A[0]=511, B[0]=-512 -> result=-261632.
- length=0 -> no mac_clr, no valid_out, done one cycle after start, result=0.
- length=12 with DEPTH=8, all entries A=1, B=2 -> exactly 8 pairs issued, result=16.
- start and wr_en asserted mid-STREAM -> both ignored, store unchanged, run result unaffected.
- Reset asserted in DRAIN -> no done, outputs at reset values next cycle.
- With MAC_FEEDER_TIMEOUT_EN: suppress mac_valid after the first strobe -> timeout=1 with done after 15 DRAIN cycles.
